// File: rtl/spu_issue_pkg.sv
// Shared types for the SPU dual-issue stage: decoded-slot layout, issue-slot
// layout, FSM states and the packing helpers used by the stage.
package spu_issue_pkg;

  localparam int SLOT_W = 79;
  localparam int OUT_W  = 75;

  localparam int W_FULL = 32;
  localparam int W_ID   = 7;
  localparam int W_REG  = 7;
  localparam int W_UNIT = 3;
  localparam int W_LAT  = 4;
  localparam int W_USE  = 3;

  // Index 0 is the first (most significant) field of a decoded slot.
  localparam int OFF_FULL = 0;
  localparam int OFF_ID   = 32;
  localparam int OFF_DST  = 39;
  localparam int OFF_UNIT = 46;
  localparam int OFF_LAT  = 49;
  localparam int OFF_WR   = 53;
  localparam int OFF_PIPE = 54;
  localparam int OFF_RA   = 55;
  localparam int OFF_RB   = 62;
  localparam int OFF_RC   = 69;
  localparam int OFF_USE  = 76;

  localparam logic [W_ID-1:0] NOP_ID = '0;

  typedef struct packed {
    logic [W_FULL-1:0] full_instr;
    logic [W_ID-1:0]   instr_id;
    logic [W_REG-1:0]  reg_dst;
    logic [W_UNIT-1:0] unit_id;
    logic [W_LAT-1:0]  latency;
    logic              reg_wr;
    logic              pipe;
    logic [W_REG-1:0]  ra;
    logic [W_REG-1:0]  rb;
    logic [W_REG-1:0]  rc;
    logic [W_USE-1:0]  src_use;  // [2]=ra, [1]=rb, [0]=rc
  } slot_t;

  typedef struct packed {
    logic [W_FULL-1:0] full_instr;
    logic [W_ID-1:0]   instr_id;
    logic [W_REG-1:0]  reg_dst;
    logic [W_UNIT-1:0] unit_id;
    logic [W_LAT-1:0]  latency;
    logic              reg_wr;
    logic [W_REG-1:0]  ra;
    logic [W_REG-1:0]  rb;
    logic [W_REG-1:0]  rc;
  } out_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PAIR   = 2'd1,
    ST_B_ONLY = 2'd2
  } state_e;

  function automatic slot_t unpack_slot(input logic [0:SLOT_W-1] v);
    slot_t s;
    s.full_instr = v[OFF_FULL +: W_FULL];
    s.instr_id   = v[OFF_ID   +: W_ID];
    s.reg_dst    = v[OFF_DST  +: W_REG];
    s.unit_id    = v[OFF_UNIT +: W_UNIT];
    s.latency    = v[OFF_LAT  +: W_LAT];
    s.reg_wr     = v[OFF_WR];
    s.pipe       = v[OFF_PIPE];
    s.ra         = v[OFF_RA   +: W_REG];
    s.rb         = v[OFF_RB   +: W_REG];
    s.rc         = v[OFF_RC   +: W_REG];
    s.src_use    = v[OFF_USE  +: W_USE];
    return s;
  endfunction

  function automatic out_t to_out(input slot_t s);
    out_t o;
    o.full_instr = s.full_instr;
    o.instr_id   = s.instr_id;
    o.reg_dst    = s.reg_dst;
    o.unit_id    = s.unit_id;
    o.latency    = s.latency;
    o.reg_wr     = s.reg_wr;
    o.ra         = s.ra;
    o.rb         = s.rb;
    o.rc         = s.rc;
    return o;
  endfunction

  function automatic out_t bubble();
    out_t o;
    o          = '0;
    o.instr_id = NOP_ID;
    return o;
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register latency scoreboard: counts down to writeback, answers busy
// queries for sources/destinations and accepts up to two new writers per cycle.
module spu_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4,
  parameter int NUM_SRC  = 6,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      src_addr [NUM_SRC],
  output logic [NUM_SRC-1:0] src_busy,
  input  logic [AW-1:0]      dst_addr [2],
  output logic [1:0]         dst_busy,
  input  logic [1:0]         set_en,
  input  logic [AW-1:0]      set_addr [2],
  input  logic [LAT_W-1:0]   set_lat  [2]
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  // A count of 1 expires at the coming edge, so a consumer deciding now lands
  // exactly L edges after its producer and is not blocked.
  function automatic logic is_busy(input logic [LAT_W-1:0] c);
    return c > LAT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_busy[i] = is_busy(cnt_q[src_addr[i]]);
    for (int k = 0; k < 2; k++)       dst_busy[k] = is_busy(cnt_q[dst_addr[k]]);
  end

  // NOTE: every element gets a default before the indexed overrides, so no latch.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
    for (int k = 0; k < 2; k++)
      if (set_en[k]) cnt_d[set_addr[k]] = (set_lat[k] == '0) ? LAT_W'(1) : set_lat[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spu_issue_stage.sv
// Dual in-order issue stage: buffers a decoded pair, checks pipe and data
// hazards against the scoreboard and the sibling, and routes to even/odd pipes.
module spu_issue_stage
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:SLOT_W-1] in_a,
  input  logic [0:SLOT_W-1] in_b,
  input  logic              flush,
  output logic [0:OUT_W-1]  out_even,
  output logic [0:OUT_W-1]  out_odd,
  output logic [31:0]       stall_cnt
);

  slot_t       in_a_s, in_b_s;
  slot_t       a_q, a_d, b_q, b_d;
  state_e      state_q, state_d;
  out_t        out_even_q, out_even_d, out_odd_q, out_odd_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [W_REG-1:0] sb_src_addr [6];
  logic [5:0]       sb_src_busy;
  logic [W_REG-1:0] sb_dst_addr [2];
  logic [1:0]       sb_dst_busy;
  logic [1:0]       sb_set_en;
  logic [W_REG-1:0] sb_set_addr [2];
  logic [LAT_W-1:0] sb_set_lat  [2];

  logic a_ok, b_sb_ok, b_raw, b_waw, a_iss, b_iss, drain, accept;

  assign in_a_s = unpack_slot(in_a);
  assign in_b_s = unpack_slot(in_b);

  // Query order matches src_use bit order: [2]=ra, [1]=rb, [0]=rc.
  always_comb begin
    sb_src_addr[0] = a_q.rc;
    sb_src_addr[1] = a_q.rb;
    sb_src_addr[2] = a_q.ra;
    sb_src_addr[3] = b_q.rc;
    sb_src_addr[4] = b_q.rb;
    sb_src_addr[5] = b_q.ra;
    sb_dst_addr[0] = a_q.reg_dst;
    sb_dst_addr[1] = b_q.reg_dst;
    sb_set_en[0]   = a_iss && a_q.reg_wr;
    sb_set_en[1]   = b_iss && b_q.reg_wr;
    sb_set_addr[0] = a_q.reg_dst;
    sb_set_addr[1] = b_q.reg_dst;
    sb_set_lat[0]  = LAT_W'(a_q.latency);
    sb_set_lat[1]  = LAT_W'(b_q.latency);
  end

  spu_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W),
    .NUM_SRC  (6)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst),
    .src_addr (sb_src_addr),
    .src_busy (sb_src_busy),
    .dst_addr (sb_dst_addr),
    .dst_busy (sb_dst_busy),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .set_lat  (sb_set_lat)
  );

  always_comb begin
    a_ok    = ~|(sb_src_busy[2:0] & a_q.src_use) && !(a_q.reg_wr && sb_dst_busy[0]);
    b_sb_ok = ~|(sb_src_busy[5:3] & b_q.src_use) && !(b_q.reg_wr && sb_dst_busy[1]);
    b_raw   = a_q.reg_wr && ((b_q.src_use[2] && b_q.ra == a_q.reg_dst) ||
                             (b_q.src_use[1] && b_q.rb == a_q.reg_dst) ||
                             (b_q.src_use[0] && b_q.rc == a_q.reg_dst));
    b_waw   = a_q.reg_wr && b_q.reg_wr && (a_q.reg_dst == b_q.reg_dst);
    a_iss   = !flush && (state_q == ST_PAIR) && a_ok;
    b_iss   = !flush && b_sb_ok &&
              ((state_q == ST_B_ONLY) ||
               (a_iss && (b_q.pipe != a_q.pipe) && !b_raw && !b_waw));
    drain   = (state_q == ST_EMPTY) ||
              (state_q == ST_PAIR   && a_iss && b_iss) ||
              (state_q == ST_B_ONLY && b_iss);
    in_ready = rst && !flush && drain;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_even_d  = bubble();
    out_odd_d   = bubble();
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_PAIR;
      a_d     = in_a_s;
      b_d     = in_b_s;
    end else if (state_q == ST_PAIR && a_iss) begin
      state_d = b_iss ? ST_EMPTY : ST_B_ONLY;
    end else if (state_q == ST_B_ONLY && b_iss) begin
      state_d = ST_EMPTY;
    end

    if (a_iss) begin
      if (a_q.pipe) out_odd_d = to_out(a_q);
      else          out_even_d = to_out(a_q);
    end
    if (b_iss) begin
      if (b_q.pipe) out_odd_d = to_out(b_q);
      else          out_even_d = to_out(b_q);
    end

    if (!flush && state_q != ST_EMPTY && !drain) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_even_q  <= '0;
      out_odd_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: payload is deliberately not reset; whether it is live is held in state_q.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign out_even  = out_even_q;
  assign out_odd   = out_odd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_spu_issue_stage.sv
// Directed bench for spu_issue_stage: a table of single pairs with hand-computed
// issue edges and stall counts, plus sequences for scoreboard, flush and reset.
module tb_spu_issue_stage;
  import spu_issue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:SLOT_W-1] in_a, in_b;
  logic              flush;
  logic [0:OUT_W-1]  out_even, out_odd;
  logic [31:0]       stall_cnt;

  always #5 clk = ~clk;

  spu_issue_stage #(.NUM_REGS(128), .LAT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .flush     (flush),
    .out_even  (out_even),
    .out_odd   (out_odd),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [6:0] id;
    logic [6:0] dst;
    logic [3:0] lat;
    logic       wr;
    logic       pipe;
    logic [6:0] ra, rb, rc;
    logic [2:0] su;
  } ins_t;

  typedef struct {
    ins_t a;
    ins_t b;
    int   a_edge;
    int   b_edge;
    int   stalls;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int               ev_cyc [128];
  int               od_cyc [128];
  logic [0:OUT_W-1] ev_val [128];
  logic [0:OUT_W-1] od_val [128];

  // Records the edge at which each instruction id shows up on each port.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_even[32:38] != 7'd0) begin
      ev_cyc[out_even[32:38]] = cyc;
      ev_val[out_even[32:38]] = out_even;
    end
    if (out_odd[32:38] != 7'd0) begin
      od_cyc[out_odd[32:38]] = cyc;
      od_val[out_odd[32:38]] = out_odd;
    end
  end

  function automatic ins_t ins(input logic [6:0] id, input logic [6:0] dst,
                               input logic [3:0] lat, input logic wr, input logic pipe,
                               input logic [6:0] ra, input logic [6:0] rb,
                               input logic [6:0] rc, input logic [2:0] su);
    ins_t r;
    r.id = id; r.dst = dst; r.lat = lat; r.wr = wr; r.pipe = pipe;
    r.ra = ra; r.rb = rb; r.rc = rc; r.su = su;
    return r;
  endfunction

  function automatic logic [0:SLOT_W-1] pack_in(input ins_t i);
    logic [31:0] full;
    full = 32'hC0DE_0000 | {25'd0, i.id};
    return {full, i.id, i.dst, i.id[2:0], i.lat, i.wr, i.pipe, i.ra, i.rb, i.rc, i.su};
  endfunction

  function automatic logic [0:OUT_W-1] pack_out(input ins_t i);
    logic [31:0] full;
    full = 32'hC0DE_0000 | {25'd0, i.id};
    return {full, i.id, i.dst, i.id[2:0], i.lat, i.wr, i.ra, i.rb, i.rc};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int port_cyc(input ins_t i, input logic other);
    return (i.pipe ^ other) ? od_cyc[i.id] : ev_cyc[i.id];
  endfunction

  function automatic logic [0:OUT_W-1] port_val(input ins_t i);
    return i.pipe ? od_val[i.id] : ev_val[i.id];
  endfunction

  task automatic run_pair(input vec_t v, input string tag);
    int          acc;
    logic [31:0] s0;
    @(negedge clk);
    s0       = stall_cnt;
    acc      = cyc + 1;
    in_a     = pack_in(v.a);
    in_b     = pack_in(v.b);
    in_valid = 1'b1;
    #1 check({tag, " ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check({tag, " A edge"},      port_cyc(v.a, 1'b0) - acc, v.a_edge);
    check({tag, " A payload"},   port_val(v.a), pack_out(v.a));
    check({tag, " A wrong port"}, port_cyc(v.a, 1'b1), -1);
    check({tag, " B edge"},      port_cyc(v.b, 1'b0) - acc, v.b_edge);
    check({tag, " B payload"},   port_val(v.b), pack_out(v.b));
    check({tag, " B wrong port"}, port_cyc(v.b, 1'b1), -1);
    check({tag, " stalls"},      stall_cnt - s0, v.stalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    int          acc;
    logic [31:0] s0;

    for (int i = 0; i < 128; i++) begin
      ev_cyc[i] = -1;
      od_cyc[i] = -1;
      ev_val[i] = '0;
      od_val[i] = '0;
    end

    //                 id     dst    lat   wr    pipe  ra     rb     rc     use
    vecs[0] = '{ins(7'd1,  7'd3,  4'd2, 1'b1, 1'b0, 7'd1,  7'd2,  7'd0,  3'b110),
                ins(7'd2,  7'd4,  4'd6, 1'b1, 1'b1, 7'd10, 7'd0,  7'd0,  3'b100), 1, 1, 0};
    vecs[1] = '{ins(7'd3,  7'd5,  4'd1, 1'b1, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd4,  7'd6,  4'd1, 1'b1, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000), 1, 2, 1};
    vecs[2] = '{ins(7'd5,  7'd7,  4'd2, 1'b1, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd6,  7'd0,  4'd1, 1'b0, 1'b1, 7'd7,  7'd0,  7'd0,  3'b100), 1, 3, 2};
    vecs[3] = '{ins(7'd7,  7'd8,  4'd3, 1'b1, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd8,  7'd8,  4'd1, 1'b1, 1'b1, 7'd0,  7'd0,  7'd0,  3'b000), 1, 4, 3};
    vecs[4] = '{ins(7'd9,  7'd11, 4'd3, 1'b0, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd10, 7'd0,  4'd1, 1'b0, 1'b1, 7'd0,  7'd11, 7'd0,  3'b010), 1, 1, 0};
    vecs[5] = '{ins(7'd11, 7'd12, 4'd0, 1'b1, 1'b1, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd12, 7'd0,  4'd1, 1'b0, 1'b0, 7'd12, 7'd0,  7'd0,  3'b100), 1, 2, 1};
    vecs[6] = '{ins(7'd13, 7'd13, 4'd4, 1'b1, 1'b0, 7'd0,  7'd0,  7'd0,  3'b000),
                ins(7'd14, 7'd0,  4'd1, 1'b0, 1'b1, 7'd13, 7'd0,  7'd13, 3'b000), 1, 1, 0};

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("ready in reset", in_ready, 1'b0);
    check("reset even bubble", out_even, '0);
    check("reset odd bubble", out_odd, '0);
    check("reset stall_cnt", stall_cnt, 32'd0);
    rst = 1'b1;
    #1 check("ready after reset", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_pair(vecs[i], $sformatf("vec%0d", i));

    // Scoreboard: consumer of r9 (L=6) lands exactly 6 edges after the producer.
    @(negedge clk);
    s0       = stall_cnt;
    acc      = cyc + 1;
    in_a     = pack_in(ins(7'd20, 7'd9, 4'd6, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b     = pack_in(ins(7'd21, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    in_valid = 1'b1;
    @(negedge clk);
    check("sb ready while draining", in_ready, 1'b1);
    in_a = pack_in(ins(7'd22, 7'd0, 4'd1, 1'b0, 1'b0, 7'd9, 7'd0, 7'd0, 3'b100));
    in_b = pack_in(ins(7'd23, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("sb producer edge", ev_cyc[20] - acc, 1);
    check("sb consumer distance", ev_cyc[22] - ev_cyc[20], 6);
    check("sb sibling with consumer", od_cyc[23] - ev_cyc[22], 0);
    check("sb stalls", stall_cnt - s0, 32'd5);

    // Flush in B_ONLY: B and the concurrently offered pair must never issue.
    @(negedge clk);
    acc      = cyc + 1;
    in_a     = pack_in(ins(7'd30, 7'd20, 4'd4, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b     = pack_in(ins(7'd31, 7'd20, 4'd1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    s0       = stall_cnt;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = pack_in(ins(7'd32, 7'd0, 4'd1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b     = pack_in(ins(7'd33, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    #1 check("flush blocks ready", in_ready, 1'b0);
    @(posedge clk);
    #2;
    check("flush even bubble", out_even, '0);
    check("flush odd bubble", out_odd, '0);
    check("flush no stall", stall_cnt, s0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 check("ready after flush", in_ready, 1'b1);
    repeat (10) @(negedge clk);
    check("flush A issued", ev_cyc[30] - acc, 1);
    check("flush B never even", ev_cyc[31], -1);
    check("flush B never odd", od_cyc[31], -1);
    check("flush pair A dropped", ev_cyc[32], -1);
    check("flush pair B dropped", od_cyc[33], -1);

    // Reset while a dependent pair waits in PAIR.
    @(negedge clk);
    in_a     = pack_in(ins(7'd40, 7'd30, 4'd8, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b     = pack_in(ins(7'd41, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    in_valid = 1'b1;
    @(negedge clk);
    in_a = pack_in(ins(7'd42, 7'd0, 4'd1, 1'b0, 1'b0, 7'd30, 7'd0, 7'd0, 3'b100));
    in_b = pack_in(ins(7'd43, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd30, 7'd0, 3'b010));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("stalling before reset", stall_cnt != 32'd0, 1'b1);
    rst = 1'b0;
    #1 check("ready low in reset", in_ready, 1'b0);
    @(posedge clk);
    #2;
    check("mid reset even bubble", out_even, '0);
    check("mid reset odd bubble", out_odd, '0);
    check("mid reset stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready after mid reset", in_ready, 1'b1);
    acc      = cyc + 1;
    in_a     = pack_in(ins(7'd44, 7'd0, 4'd1, 1'b0, 1'b0, 7'd30, 7'd0, 7'd0, 3'b100));
    in_b     = pack_in(ins(7'd45, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd30, 7'd0, 3'b010));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("post reset A immediate", ev_cyc[44] - acc, 1);
    check("post reset B immediate", od_cyc[45] - acc, 1);
    check("discarded A absent", ev_cyc[42], -1);
    check("discarded B absent", od_cyc[43], -1);

    // Back-to-back independent pairs sustain one pair per cycle.
    @(negedge clk);
    s0       = stall_cnt;
    in_a     = pack_in(ins(7'd50, 7'd0, 4'd1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b     = pack_in(ins(7'd51, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    in_valid = 1'b1;
    @(negedge clk);
    check("stream second ready", in_ready, 1'b1);
    in_a = pack_in(ins(7'd52, 7'd0, 4'd1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000));
    in_b = pack_in(ins(7'd53, 7'd0, 4'd1, 1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stream spacing", ev_cyc[52] - ev_cyc[50], 1);
    check("stream odd spacing", od_cyc[53] - od_cyc[51], 1);
    check("stream no stall", stall_cnt - s0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
